line_consensus_solver: RTL
==========================

// Module: line_consensus_solver
// PURPOSE
//  Parametrised successor of the 3x3 nonogram line solver (board up to MAX_SIZE x MAX_SIZE).
//  Consumes a stream: line index, then that line's candidate options from the option FIFO.
//  Flags each option consistent or conflicting with the board (FIFO put-back) and counts the survivors.
//  Commits cells on which all survivors agree; reports unsatisfiable lines and board completion.
// PARAMETERS
//  MAX_SIZE  11  max rows/cols; line indices 0..2*MAX_SIZE-1 (rows first, then columns)
//  AMNT_W    7   width of each per-line option count
// PORTS
//  clk               in   1                    system clock
//  rst               in   1                    synchronous, active-high reset
//  started           in   1                    pulse: clear board, begin new puzzle
//  valid_in          in   1                    option word valid; transfer when valid_in & ready
//  ready             out  1                    solver accepts a word this cycle
//  option            in   MAX_SIZE             line index (zero-extended) or option pattern
//  num_rows          in   $clog2(MAX_SIZE+1)   active rows R
//  num_cols          in   $clog2(MAX_SIZE+1)   active cols C
//  old_options_amnt  in   2*MAX_SIZE*AMNT_W    option count per line; line l at [l*AMNT_W +: AMNT_W]
//  new_line          out  1                    1-cycle pulse: line index accepted
//  line_index        out  $clog2(2*MAX_SIZE)   current line
//  put_back_valid    out  1                    1-cycle pulse per option accepted
//  put_back_to_FIFO  out  1                    option consistent (re-queue); valid with put_back_valid
//  new_options_amnt  out  AMNT_W               consistent-option count; valid with amnt_valid
//  amnt_valid        out  1                    1-cycle pulse at line commit
//  assigned          out  MAX_SIZE*MAX_SIZE    cell values; cell (r,c) at bit r*MAX_SIZE+c
//  known             out  MAX_SIZE*MAX_SIZE    cell-determined flags, same mapping
//  solved            out  1                    all R x C cells known
//  unsat             out  1                    sticky: some line had zero consistent options
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (ready=0, board cleared, solved=0, unsat=0). rst wins over all.
//  Line l<R is row l (len=C, cell i=(l,i)); l>=R is column l-R (len=R, cell i=(i,l-R)).
//  Option bit option[len-1-i] is cell i (MSB-first); bits >= len ignored.
//  FSM: IDLE -started-> WAIT_IDX; WAIT_IDX -idx-> CHECK (or COMMIT if amnt==0);
//       CHECK -last option-> COMMIT; COMMIT -> WAIT_IDX (always 1 cycle).
//  started in any non-reset state: clear known/assigned/solved/unsat, go WAIT_IDX; overrides valid_in.
//  ready=1 in WAIT_IDX and CHECK; 0 in IDLE and COMMIT.
//  WAIT_IDX accept: if index >= R+C, word dropped, no new_line, stay. Else latch line, remaining
//   = old_options_amnt[line], clear count, acc_and=all 1, acc_or=0; new_line next cycle.
//  CHECK accept: conflict = any i<len with known[i] & (opt[i]!=assigned[i]).
//   Next cycle: put_back_valid=1, put_back_to_FIFO=!conflict. Non-conflicting: count+1,
//   acc_and&=opt, acc_or|=opt. remaining-1; at 0 go COMMIT.
//  COMMIT: amnt_valid=1, new_options_amnt=count. If count>0: for i<len, acc_and[i]=1 -> known=1,
//   assigned=1; acc_or[i]=0 -> known=1, assigned=0; other cells unchanged. If count==0:
//   board unchanged, unsat<=1. Board visible the cycle after COMMIT; solved updates same cycle.
//  Count saturates at 2^AMNT_W-1. Known cells never cleared except by started/rst.
//  rst mid-line: partial accumulators discarded, no amnt_valid emitted.
//  solved = AND of known over r<R, c<C; re-evaluated only on commit/clear.
// TESTING
//  3x3: started; idx 0, opts 110,011 (amnt 2) -> put_back 1,1; amnt=2; cell(0,1) known=1,assigned=1.
//  idx 2 (amnt 1), opt 101 -> row 2 known=111, assigned=101; ready=0 during COMMIT cycle.
//  idx 3 opt 101, then idx 0 opts 110,011 -> put_back 1,0; amnt=1; row 0 assigned=110 all known.
//  idx 5 opt 010 with (0,2)=0,(2,2)=1 known -> put_back 0, amnt=0, unsat=1, board unchanged.
//  Full 3x3 (110/010/101) fed all lines -> solved=1 cycle after final commit; idx 7 dropped.
//  11x11: rst asserted mid-CHECK -> all outputs 0, ready=0; started -> WAIT_IDX, ready=1.

Source files
------------

// File: rtl/line_consensus_solver.sv
// line_consensus_solver: streams per-line options, flags conflicts with the board, commits cells all survivors agree on
module line_consensus_solver #(
  parameter int MAX_SIZE = 11,
  parameter int AMNT_W = 7
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                started,
  input  logic                                valid_in,
  output logic                                ready,
  input  logic [MAX_SIZE-1:0]                 option,
  input  logic [$clog2(MAX_SIZE+1)-1:0]       num_rows,
  input  logic [$clog2(MAX_SIZE+1)-1:0]       num_cols,
  input  logic [2*MAX_SIZE*AMNT_W-1:0]        old_options_amnt,
  output logic                                new_line,
  output logic [$clog2(2*MAX_SIZE)-1:0]       line_index,
  output logic                                put_back_valid,
  output logic                                put_back_to_FIFO,
  output logic [AMNT_W-1:0]                   new_options_amnt,
  output logic                                amnt_valid,
  output logic [MAX_SIZE*MAX_SIZE-1:0]        assigned,
  output logic [MAX_SIZE*MAX_SIZE-1:0]        known,
  output logic                                solved,
  output logic                                unsat
);
  localparam int NW = $clog2(MAX_SIZE+1);
  localparam int LW = $clog2(2*MAX_SIZE);
  localparam int CELLS = MAX_SIZE*MAX_SIZE;
  typedef enum logic [1:0] {IDLE, WAIT_IDX, CHECK, COMMIT} state_t;
  state_t r_state, w_next;
  logic [LW-1:0] r_line, w_idx, w_sel, w_col;
  logic [AMNT_W-1:0] r_rem, r_cnt, w_amnt;
  logic [MAX_SIZE-1:0] r_and, r_or, w_opt, w_lk, w_la;
  logic [CELLS-1:0] r_known, r_assigned, w_known_nx, w_assigned_nx, w_active;
  logic r_solved, r_unsat, r_new_line, r_pb_valid, r_pb_fifo;
  logic w_idx_ok, w_is_col, w_conflict, w_solved_nx;
  logic [NW-1:0] w_len;
  int w_cell [MAX_SIZE];
  assign w_idx = option[LW-1:0];
  assign w_idx_ok = int'(option) < int'(num_rows) + int'(num_cols);
  assign w_sel = w_idx_ok ? w_idx : '0;
  assign w_amnt = old_options_amnt[int'(w_sel)*AMNT_W +: AMNT_W];
  assign w_is_col = r_line >= LW'(num_rows);
  assign w_col = r_line - LW'(num_rows);
  assign w_len = w_is_col ? num_rows : num_cols;
  assign w_conflict = |(w_lk & (w_opt ^ w_la));
  // Line positions are gathered LSB = cell 0 so accumulators are line-relative
  always_comb begin
    w_opt = '0;
    w_lk = '0;
    w_la = '0;
    w_known_nx = r_known;
    w_assigned_nx = r_assigned;
    w_active = '0;
    for (int i = 0; i < MAX_SIZE; i++) begin
      w_cell[i] = w_is_col ? i*MAX_SIZE + int'(w_col) : int'(r_line)*MAX_SIZE + i;
      if (i < int'(w_len)) begin
        w_opt[i] = option[int'(w_len)-1-i];
        w_lk[i] = r_known[w_cell[i]];
        w_la[i] = r_assigned[w_cell[i]];
        if (r_cnt != '0 && (r_and[i] || !r_or[i])) begin
          w_known_nx[w_cell[i]] = 1'b1;
          w_assigned_nx[w_cell[i]] = r_and[i];
        end
      end
    end
    for (int r = 0; r < MAX_SIZE; r++)
      for (int c = 0; c < MAX_SIZE; c++)
        w_active[r*MAX_SIZE+c] = (r < int'(num_rows)) && (c < int'(num_cols));
    w_solved_nx = &(w_known_nx | ~w_active);
  end
  always_comb begin
    w_next = started ? WAIT_IDX
           : (r_state == WAIT_IDX && valid_in && w_idx_ok) ? (w_amnt == '0 ? COMMIT : CHECK)
           : (r_state == CHECK && valid_in && r_rem == AMNT_W'(1)) ? COMMIT
           : (r_state == COMMIT) ? WAIT_IDX
           : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_line <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_and <= '0;
      r_or <= '0;
      r_known <= '0;
      r_assigned <= '0;
      r_solved <= 1'b0;
      r_unsat <= 1'b0;
      r_new_line <= 1'b0;
      r_pb_valid <= 1'b0;
      r_pb_fifo <= 1'b0;
    end else begin
      r_state <= w_next;
      r_new_line <= 1'b0;
      r_pb_valid <= 1'b0;
      r_pb_fifo <= 1'b0;
      if (started) begin
        r_known <= '0;
        r_assigned <= '0;
        r_solved <= 1'b0;
        r_unsat <= 1'b0;
      end else if (r_state == WAIT_IDX && valid_in && w_idx_ok) begin
        r_line <= w_idx;
        r_rem <= w_amnt;
        r_cnt <= '0;
        r_and <= '1;
        r_or <= '0;
        r_new_line <= 1'b1;
      end else if (r_state == CHECK && valid_in) begin
        r_pb_valid <= 1'b1;
        r_pb_fifo <= !w_conflict;
        r_rem <= r_rem - 1'b1;
        if (!w_conflict) begin
          r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
          r_and <= r_and & w_opt;
          r_or <= r_or | w_opt;
        end
      end else if (r_state == COMMIT) begin
        r_known <= w_known_nx;
        r_assigned <= w_assigned_nx;
        r_solved <= w_solved_nx;
        r_unsat <= r_unsat | (r_cnt == '0);
      end
    end
  end
  assign ready = (r_state == WAIT_IDX) || (r_state == CHECK);
  assign new_line = r_new_line;
  assign line_index = r_line;
  assign put_back_valid = r_pb_valid;
  assign put_back_to_FIFO = r_pb_fifo;
  assign new_options_amnt = r_cnt;
  assign amnt_valid = (r_state == COMMIT);
  assign assigned = r_assigned;
  assign known = r_known;
  assign solved = r_solved;
  assign unsat = r_unsat;
endmodule
